// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control FSM: state encodings,
// opcodes, datapath select codes and the raw control word.
package mips_multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_out_decode.sv
// Moore output decode: current state (plus memory ready for the gated
// FETCH enables) to raw control word. Unused encodings yield all zeros.
module mips_multicycle_ctrl_out_decode
  import mips_multicycle_ctrl_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_src    = PC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      // Write is level-valid for the whole wait, not a single strobe.
      S_MEMWR: begin
        ctrl_o.iord      = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALU_SUB;
        ctrl_o.branch    = 1'b1;
        ctrl_o.pc_src    = PC_ALUOUT;
      end
      S_ADDIWB: begin
        ctrl_o.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_write = 1'b1;
        ctrl_o.pc_src   = PC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register, next-state logic and the
// reset gating of all datapath enables.
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               funct_valid,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               ir_write,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_src,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  state_e state_q, state_d;
  ctrl_t  ctrl;
  logic   ready;
  logic   illegal;

  assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

  always_comb begin
    state_d = S_FETCH;
    illegal = 1'b0;
    case (state_q)
      S_FETCH:  state_d = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = funct_valid ? S_EXEC : S_FETCH;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
        illegal = (state_d == S_FETCH);
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  mips_multicycle_ctrl_out_decode u_out_decode (
    .state_i     (state_q),
    .mem_ready_i (ready),
    .ctrl_o      (ctrl)
  );

  // Enables drop combinationally under reset; mux selects are harmless.
  assign pc_en      = !rst & (ctrl.pc_write | (ctrl.branch & zero));
  assign ir_write   = !rst & ctrl.ir_write;
  assign mem_read   = !rst & ctrl.mem_read;
  assign mem_write  = !rst & ctrl.mem_write;
  assign reg_write  = !rst & ctrl.reg_write;
  assign illegal_op = !rst & illegal;
  assign iord       = ctrl.iord;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_src     = ctrl.pc_src;
  assign state_dbg  = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: one instance waits on mem_ready,
// a second ignores it. Expected state + control word per cycle via scoreboard.
module tb_mips_multicycle_ctrl;
  import mips_multicycle_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst, rst2;
  logic [5:0] opcode;
  logic       funct_valid, zero, mem_ready;

  logic       pc_en0, ir_write0, iord0, mem_read0, mem_write0, reg_write0;
  logic       reg_dst0, mem_to_reg0, alu_src_a0, illegal_op0;
  logic [1:0] alu_src_b0, alu_op0, pc_src0;
  logic [3:0] state_dbg0;
  logic       pc_en1, ir_write1, iord1, mem_read1, mem_write1, reg_write1;
  logic       reg_dst1, mem_to_reg1, alu_src_a1, illegal_op1;
  logic [1:0] alu_src_b1, alu_op1, pc_src1;
  logic [3:0] state_dbg1;

  logic [19:0] obs0, obs1;
  assign obs0 = {state_dbg0, pc_en0, ir_write0, iord0, mem_read0, mem_write0, reg_write0,
                 reg_dst0, mem_to_reg0, alu_src_a0, alu_src_b0, alu_op0, pc_src0, illegal_op0};
  assign obs1 = {state_dbg1, pc_en1, ir_write1, iord1, mem_read1, mem_write1, reg_write1,
                 reg_dst1, mem_to_reg1, alu_src_a1, alu_src_b1, alu_op1, pc_src1, illegal_op1};

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.MEM_WAIT_EN(1'b1), .STATE_W(4)) dut0 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct_valid(funct_valid), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en0), .ir_write(ir_write0), .iord(iord0),
    .mem_read(mem_read0), .mem_write(mem_write0), .reg_write(reg_write0),
    .reg_dst(reg_dst0), .mem_to_reg(mem_to_reg0), .alu_src_a(alu_src_a0),
    .alu_src_b(alu_src_b0), .alu_op(alu_op0), .pc_src(pc_src0),
    .illegal_op(illegal_op0), .state_dbg(state_dbg0)
  );

  mips_multicycle_ctrl #(.MEM_WAIT_EN(1'b0), .STATE_W(4)) dut1 (
    .clk(clk), .rst(rst2), .opcode(opcode), .funct_valid(funct_valid), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en1), .ir_write(ir_write1), .iord(iord1),
    .mem_read(mem_read1), .mem_write(mem_write1), .reg_write(reg_write1),
    .reg_dst(reg_dst1), .mem_to_reg(mem_to_reg1), .alu_src_a(alu_src_a1),
    .alu_src_b(alu_src_b1), .alu_op(alu_op1), .pc_src(pc_src1),
    .illegal_op(illegal_op1), .state_dbg(state_dbg1)
  );

  // Word layout: pc_en ir_write iord mem_read mem_write reg_write reg_dst
  // mem_to_reg alu_src_a alu_src_b[2] alu_op[2] pc_src[2] illegal_op.
  localparam logic [15:0] BASE [16] = '{
    16'h1020, 16'h0060, 16'h00C0, 16'h3000, 16'h0500, 16'h2800, 16'h0090, 16'h0600,
    16'h008A, 16'h00C0, 16'h0400, 16'h8004, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
  localparam logic [15:0] RST_MASK = 16'h23FE;

  typedef struct {
    string       tag;
    logic [19:0] exp;
  } sb_t;
  sb_t sb[$];
  int  vectors = 0;
  int  miscompares = 0;

  task automatic cyc(input int which, input logic [3:0] st, input logic ill, input string tag);
    logic [15:0] w;
    logic [19:0] o;
    logic        r, rdy;
    sb_t         e;
    r   = (which != 0) ? rst2 : rst;
    rdy = (which != 0) ? 1'b1 : mem_ready;
    w   = BASE[st];
    if (st == 4'd0 && rdy)  w = w | 16'hC000;
    if (st == 4'd8 && zero) w = w | 16'h8000;
    if (ill)                w = w | 16'h0001;
    if (r)                  w = w & RST_MASK;
    sb.push_back('{tag, {st, w}});
    @(negedge clk);
    e = sb.pop_front();
    o = (which != 0) ? obs1 : obs0;
    vectors++;
    assert (o === e.exp) else begin
      miscompares++;
      $error("FAIL %s: observed state/ctrl %h, expected %h", e.tag, o, e.exp);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; opcode = OP_LW; funct_valid = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    cyc(0, S_FETCH, 0, "rst_hold0");
    cyc(1, S_FETCH, 0, "rst_hold1");

    rst = 1'b0;
    cyc(0, S_FETCH,  0, "lw_fetch");
    cyc(0, S_DECODE, 0, "lw_decode");
    cyc(0, S_MEMADR, 0, "lw_memadr");
    cyc(0, S_MEMRD,  0, "lw_memrd");
    cyc(0, S_MEMWB,  0, "lw_memwb");

    opcode = OP_SW;
    cyc(0, S_FETCH,  0, "sw_fetch");
    cyc(0, S_DECODE, 0, "sw_decode");
    cyc(0, S_MEMADR, 0, "sw_memadr");
    mem_ready = 1'b0; opcode = OP_BEQ;
    for (int i = 0; i < 3; i++) cyc(0, S_MEMWR, 0, "sw_memwr_wait");
    mem_ready = 1'b1;
    cyc(0, S_MEMWR, 0, "sw_memwr_done");

    zero = 1'b1;
    cyc(0, S_FETCH,  0, "beq1_fetch");
    cyc(0, S_DECODE, 0, "beq1_decode");
    cyc(0, S_BRANCH, 0, "beq1_taken");
    zero = 1'b0; mem_ready = 1'b0;
    cyc(0, S_FETCH,  0, "beq0_fetch_wait");
    mem_ready = 1'b1;
    cyc(0, S_FETCH,  0, "beq0_fetch");
    cyc(0, S_DECODE, 0, "beq0_decode");
    cyc(0, S_BRANCH, 0, "beq0_not_taken");

    opcode = 6'b111111;
    cyc(0, S_FETCH,  0, "ill_fetch");
    cyc(0, S_DECODE, 1, "ill_decode");
    opcode = OP_RTYPE;
    cyc(0, S_FETCH,  0, "badfn_fetch");
    cyc(0, S_DECODE, 1, "badfn_decode");
    funct_valid = 1'b1;
    cyc(0, S_FETCH,  0, "rtype_fetch");
    cyc(0, S_DECODE, 0, "rtype_decode");
    cyc(0, S_EXEC,   0, "rtype_exec");
    cyc(0, S_ALUWB,  0, "rtype_aluwb");

    opcode = OP_ADDI;
    cyc(0, S_FETCH,  0, "addi_fetch");
    cyc(0, S_DECODE, 0, "addi_decode");
    cyc(0, S_ADDIEX, 0, "addi_ex");
    cyc(0, S_ADDIWB, 0, "addi_wb");
    opcode = OP_J;
    cyc(0, S_FETCH,  0, "j_fetch");
    cyc(0, S_DECODE, 0, "j_decode");
    cyc(0, S_JUMP,   0, "j_jump");

    opcode = OP_LW;
    cyc(0, S_FETCH,  0, "abort_fetch");
    cyc(0, S_DECODE, 0, "abort_decode");
    cyc(0, S_MEMADR, 0, "abort_memadr");
    mem_ready = 1'b0;
    cyc(0, S_MEMRD,  0, "abort_memrd_wait");
    rst = 1'b1;
    cyc(0, S_MEMRD,  0, "abort_memrd_rst");
    rst = 1'b0;
    cyc(0, S_FETCH,  0, "abort_fetch_wait1");
    cyc(0, S_FETCH,  0, "abort_fetch_wait2");
    mem_ready = 1'b1;
    cyc(0, S_FETCH,  0, "abort_fetch_go");
    cyc(0, S_DECODE, 0, "abort_decode2");

    rst = 1'b1; rst2 = 1'b0; mem_ready = 1'b0; opcode = OP_RTYPE; funct_valid = 1'b1;
    cyc(1, S_FETCH,  0, "nw_rtype_fetch");
    cyc(1, S_DECODE, 0, "nw_rtype_decode");
    cyc(1, S_EXEC,   0, "nw_rtype_exec");
    cyc(1, S_ALUWB,  0, "nw_rtype_aluwb");
    opcode = OP_LW;
    cyc(1, S_FETCH,  0, "nw_lw_fetch");
    cyc(1, S_DECODE, 0, "nw_lw_decode");
    cyc(1, S_MEMADR, 0, "nw_lw_memadr");
    cyc(1, S_MEMRD,  0, "nw_lw_memrd");
    cyc(1, S_MEMWB,  0, "nw_lw_memwb");
    cyc(1, S_FETCH,  0, "nw_lw_done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
